// File: rtl/sram_valid_array.sv
// sram_valid_array: storage array with per-entry valid bits, independent write
// and read-and-consume ports, occupancy counter and full/almost_full/empty decode.
// Optional feature macro: SRAM_VALID_ERR_EN enables the sticky error flags
// err_overwrite and err_rd_empty; without it both flags are tied low.
module sram_valid_array #(
  parameter int SRAM_BIT  = 128,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AF_MARGIN = 1
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SRAM_BIT-1:0] wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SRAM_BIT-1:0] rd_data,
  output logic                rd_valid,
  output logic [DEPTH-1:0]    valid_vec,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                almost_full,
  output logic                empty,
  output logic                err_overwrite,
  output logic                err_rd_empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(DEPTH - AF_MARGIN);

  logic [SRAM_BIT-1:0] mem [DEPTH];
  logic [DEPTH-1:0]    valid_nxt;
  logic                same_addr;
  logic                cnt_inc;
  logic                cnt_dec;

  // Next occupancy: the read clears its entry first, so a same-address write wins.
  always_comb begin
    same_addr = (wr_addr == rd_addr);
    valid_nxt = valid_vec;
    if (rd_en) valid_nxt[rd_addr] = 1'b0;
    if (wr_en) valid_nxt[wr_addr] = 1'b1;
    cnt_inc = wr_en && !valid_vec[wr_addr];
    cnt_dec = rd_en && valid_vec[rd_addr] && !(wr_en && same_addr);
  end

  // Data storage has no reset; writes are suppressed while reset is asserted.
  always_ff @(posedge CLK) begin
    if (rst_n && wr_en) mem[wr_addr] <= wr_data;
  end

  // Occupancy bits, counter and read port; read data is the pre-edge contents.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      valid_vec <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      valid_vec <= valid_nxt;
      count     <= count + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
      rd_valid  <= rd_en && valid_vec[rd_addr];
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

  // Status decode from the registered count.
  always_comb begin
    full        = (count == FULL_CNT);
    empty       = (count == '0);
    almost_full = (count >= AF_CNT) && !full;
  end

`ifdef SRAM_VALID_ERR_EN
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      err_overwrite <= 1'b0;
      err_rd_empty  <= 1'b0;
    end else begin
      if (wr_en && valid_vec[wr_addr] && !(rd_en && same_addr)) err_overwrite <= 1'b1;
      if (rd_en && !valid_vec[rd_addr]) err_rd_empty <= 1'b1;
    end
  end
`else
  assign err_overwrite = 1'b0;
  assign err_rd_empty  = 1'b0;
`endif

endmodule

// File: tb/tb_sram_valid_array.sv
// Directed self-checking bench for sram_valid_array (default parameters).
module tb_sram_valid_array;

`ifdef SRAM_VALID_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [127:0] wr_data;
  logic         rd_en;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic [15:0]  valid_vec;
  logic [4:0]   count;
  logic         full, almost_full, empty, err_overwrite, err_rd_empty;

  int tests = 0;
  int fails = 0;

  sram_valid_array dut (
    .CLK(CLK), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .valid_vec(valid_vec), .count(count),
    .full(full), .almost_full(almost_full), .empty(empty),
    .err_overwrite(err_overwrite), .err_rd_empty(err_rd_empty)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given strobes, then strobes drop; outputs sampled 1ns after the edge.
  task automatic cyc(input logic rn, input logic we, input logic [3:0] wa, input logic [127:0] wd,
                     input logic re, input logic [3:0] ra);
    rst_n = rn; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    @(posedge CLK);
    #1;
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;

    // reset with a write strobe present
    cyc(0, 1, 4'd0, 128'hEE, 0, 4'd0);
    cyc(0, 1, 4'd0, 128'hEE, 0, 4'd0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_vv", valid_vec, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_rdd", rd_data, 0);
    chk("rst_eov", err_overwrite, 0);
    chk("rst_erd", err_rd_empty, 0);

    // fill 0..15, data = addr except addr 3 holds 0x33
    for (int i = 0; i < 15; i++) cyc(1, 1, 4'(i), (i == 3) ? 128'h33 : 128'(i), 0, 4'd0);
    chk("fill15_count", count, 15);
    chk("fill15_af", almost_full, 1);
    chk("fill15_full", full, 0);
    cyc(1, 1, 4'd15, 128'd15, 0, 4'd0);
    chk("fill16_count", count, 16);
    chk("fill16_full", full, 1);
    chk("fill16_af", almost_full, 0);
    chk("fill16_vv", valid_vec, 16'hFFFF);
    chk("fill16_empty", empty, 0);

    // read addr 5 from full
    cyc(1, 0, 4'd0, 128'h0, 1, 4'd5);
    chk("rd5_data", rd_data, 5);
    chk("rd5_valid", rd_valid, 1);
    chk("rd5_count", count, 15);
    chk("rd5_vv5", valid_vec[5], 0);
    chk("rd5_af", almost_full, 1);
    chk("rd5_full", full, 0);

    // idle: data held, rd_valid low
    cyc(1, 0, 4'd0, 128'h0, 0, 4'd0);
    chk("idle_data", rd_data, 5);
    chk("idle_valid", rd_valid, 0);

    // same-cycle write 0xAA and read on addr 3
    cyc(1, 1, 4'd3, 128'hAA, 1, 4'd3);
    chk("rw3_data", rd_data, 128'h33);
    chk("rw3_valid", rd_valid, 1);
    chk("rw3_vv3", valid_vec[3], 1);
    chk("rw3_count", count, 15);
    chk("rw3_eov", err_overwrite, 0);

    // consume addr 3: new data visible
    cyc(1, 0, 4'd0, 128'h0, 1, 4'd3);
    chk("rd3_data", rd_data, 128'hAA);
    chk("rd3_count", count, 14);
    chk("rd3_vv", valid_vec, 16'hFFD7);

    // write empty addr 5 while reading valid addr 6: net zero
    cyc(1, 1, 4'd5, 128'h55, 1, 4'd6);
    chk("w5r6_data", rd_data, 6);
    chk("w5r6_valid", rd_valid, 1);
    chk("w5r6_count", count, 14);
    chk("w5r6_vv", valid_vec, 16'hFFB7);

    // read invalid addr 3: stored data, rd_valid low
    cyc(1, 0, 4'd0, 128'h0, 1, 4'd3);
    chk("rdinv_data", rd_data, 128'hAA);
    chk("rdinv_valid", rd_valid, 0);
    chk("rdinv_count", count, 14);
    chk("rdinv_erd", err_rd_empty, ERR_EXP);
    chk("rdinv_eov", err_overwrite, 0);

    // overwrite valid addr 0
    cyc(1, 1, 4'd0, 128'h70, 0, 4'd0);
    chk("ow0_count", count, 14);
    chk("ow0_eov", err_overwrite, ERR_EXP);

    // reset clears flags
    cyc(0, 0, 4'd0, 128'h0, 0, 4'd0);
    chk("rst2_count", count, 0);
    chk("rst2_eov", err_overwrite, 0);
    chk("rst2_erd", err_rd_empty, 0);
    chk("rst2_rdd", rd_data, 0);

    // write addr 2 twice
    cyc(1, 1, 4'd2, 128'h22, 0, 4'd0);
    cyc(1, 1, 4'd2, 128'h23, 0, 4'd0);
    chk("w2x2_count", count, 1);
    chk("w2x2_vv", valid_vec, 16'h0004);
    chk("w2x2_eov", err_overwrite, ERR_EXP);

    // from empty, read addr 7 (memory kept its old contents through reset)
    cyc(0, 0, 4'd0, 128'h0, 0, 4'd0);
    cyc(1, 0, 4'd0, 128'h0, 1, 4'd7);
    chk("rde_data", rd_data, 7);
    chk("rde_valid", rd_valid, 0);
    chk("rde_count", count, 0);
    chk("rde_empty", empty, 1);
    chk("rde_erd", err_rd_empty, ERR_EXP);

    // count 9 then reset together with a write
    cyc(0, 0, 4'd0, 128'h0, 0, 4'd0);
    for (int i = 0; i < 9; i++) cyc(1, 1, 4'(i), 128'h90 + 128'(i), 0, 4'd0);
    chk("c9_count", count, 9);
    cyc(0, 1, 4'd9, 128'hEE, 0, 4'd0);
    chk("rstw_count", count, 0);
    chk("rstw_empty", empty, 1);
    chk("rstw_vv", valid_vec, 0);
    chk("rstw_rdv", rd_valid, 0);
    cyc(1, 0, 4'd0, 128'h0, 1, 4'd9);
    chk("rstw_mem9", rd_data, 9);
    chk("rstw_rdv9", rd_valid, 0);

    // fill, then write while full and simultaneous read/write while full
    for (int i = 0; i < 16; i++) cyc(1, 1, 4'(i), 128'(i), 0, 4'd0);
    chk("refill_count", count, 16);
    cyc(1, 1, 4'd4, 128'h44, 0, 4'd0);
    chk("wfull_count", count, 16);
    chk("wfull_full", full, 1);
    cyc(1, 1, 4'd4, 128'h45, 1, 4'd4);
    chk("rwfull_data", rd_data, 128'h44);
    chk("rwfull_count", count, 16);
    cyc(1, 0, 4'd0, 128'h0, 1, 4'd4);
    chk("rd4_data", rd_data, 128'h45);
    chk("rd4_count", count, 15);
    chk("rd4_af", almost_full, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
